uart_tx_fifo_ctrl: RTL and testbench

Transmit-side byte buffer and launch controller sitting directly upstream of the UART transmit interface. Accepts bytes from a host write port into a circular FIFO. Pops one byte at a time onto `TxData` with a single-cycle `transmit` strobe, then waits for the transmitter's `tx_busy` to rise and fall before launching the next. Decouples bursty host writes from the serial bit rate.

---
 rtl/uart_tx_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit-side byte FIFO with a launch controller: pops one byte per UART frame,
// strobes transmit, then waits for tx_busy to rise and fall (or time out) before the next.
module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    tx_busy,
  output logic                    transmit,
  output logic [DATA_WIDTH-1:0]   TxData,
  output logic                    tx_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [TW-1:0]         timer;
  logic                  wr_accept, pop, timer_clr, timer_inc, timeout;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // A write while full is rejected even if a pop happens on the same edge.
  assign wr_accept = wr_en && !full;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          timer_clr  = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      transmit <= 1'b0;
      overflow <= 1'b0;
      tx_error <= 1'b0;
      TxData   <= '0;
    end else begin
      state    <= state_next;
      transmit <= pop;
      overflow <= wr_en && full;
      tx_error <= timeout;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        TxData <= mem[rd_ptr];
      end
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl: directed vector table, directed corner
// sequences, and randomized traffic scored against a queue-based reference model.
module tb_uart_tx_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BT    = 32;

  logic          clk = 1'b0;
  logic          reset, wr_en, tx_busy;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, transmit, tx_error;
  logic [4:0]    count;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .transmit(transmit), .TxData(tx_data), .tx_error(tx_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus launch phase (0 ready, 1 awaiting busy, 2 awaiting idle).
  logic [DW-1:0] mq[$];
  int            phase = 0;
  int            wcnt  = 0;
  logic [DW-1:0] exp_txd = '0;
  int            cyc = 0;
  logic [DW-1:0] launched[$];
  int            tx_cycles[$];
  int            err_cycles[$];

  // Transmitter model.
  typedef enum int {XM_MANUAL, XM_HIGH, XM_LOW, XM_AUTO} xmode_t;
  xmode_t xmode = XM_MANUAL;
  bit     xm_random = 1'b0;
  int     xm_len_fixed = 10;
  bit     xm_on = 1'b0;
  int     xm_wait = 0;
  int     xm_len = 0;

  task automatic drive_xmtr();
    case (xmode)
      XM_HIGH: tx_busy = 1'b1;
      XM_LOW:  tx_busy = 1'b0;
      XM_AUTO: begin
        if (transmit) begin
          if (xm_random) begin
            xm_on   = ($urandom_range(9) != 0);
            xm_wait = $urandom_range(3);
            xm_len  = $urandom_range(8, 1);
          end else begin
            xm_on   = 1'b1;
            xm_wait = 0;
            xm_len  = xm_len_fixed;
          end
        end
        if (xm_on) begin
          if (xm_wait > 0) begin
            tx_busy = 1'b0;
            xm_wait--;
          end else if (xm_len > 0) begin
            tx_busy = 1'b1;
            xm_len--;
          end else begin
            tx_busy = 1'b0;
            xm_on   = 1'b0;
          end
        end else begin
          tx_busy = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: snapshot inputs, advance the model across the edge, compare, drive transmitter.
  task automatic step();
    logic          rst_p, wr_p, busy_p;
    logic [DW-1:0] d_p;
    int            pre_size;
    bit            launch_ok, exp_err, exp_ovf;
    rst_p = reset; wr_p = wr_en; busy_p = tx_busy; d_p = wr_data;
    @(posedge clk);
    #1;
    cyc++;
    launch_ok = 1'b0; exp_err = 1'b0; exp_ovf = 1'b0;
    if (rst_p) begin
      mq.delete();
      phase = 0; wcnt = 0; exp_txd = '0;
    end else begin
      pre_size  = mq.size();
      launch_ok = (phase == 0) && (pre_size > 0) && !busy_p;
      case (phase)
        0: if (launch_ok) begin phase = 1; wcnt = 0; end
        1: begin
          if (busy_p) phase = 2;
          else begin
            wcnt++;
            if (wcnt == BT) begin exp_err = 1'b1; phase = 0; end
          end
        end
        default: if (!busy_p) phase = 0;
      endcase
      if (launch_ok) exp_txd = mq.pop_front();
      if (wr_p) begin
        if (pre_size < DEPTH) mq.push_back(d_p);
        else exp_ovf = 1'b1;
      end
    end
    check("transmit", transmit, launch_ok);
    check("tx_data", tx_data, exp_txd);
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("overflow", overflow, exp_ovf);
    check("tx_error", tx_error, exp_err);
    if (transmit) begin
      launched.push_back(tx_data);
      tx_cycles.push_back(cyc);
    end
    if (tx_error) err_cycles.push_back(cyc);
    drive_xmtr();
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    wr_en = 1'b0;
    while ((mq.size() != 0 || phase != 0 || tx_busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain_in_budget"}, n < budget, 1);
    check({name, "_empty_at_end"}, empty, 1);
  endtask

  typedef struct packed {
    logic          rst;
    logic          wr;
    logic          busy;
    logic [DW-1:0] data;
    logic [4:0]    cnt;
    logic          emp;
    logic          ful;
    logic          tx;
    logic          ovf;
    logic [DW-1:0] txd;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // rst wr busy data cnt emp ful tx ovf txd
    vecs = '{
      '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C},
      '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C},
      '{1'b0, 1'b1, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C},
      '{1'b0, 1'b1, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C},
      '{1'b0, 1'b1, 1'b1, 8'h33, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C},
      '{1'b0, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C},
      '{1'b0, 1'b1, 1'b0, 8'h44, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11},
      '{1'b0, 1'b0, 1'b1, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11}
    };

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0;

    // Reset with writes, single byte, busy handshake gating, simultaneous pop/write.
    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst; wr_en = vecs[i].wr; tx_busy = vecs[i].busy; wr_data = vecs[i].data;
      step();
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_empty", i), empty, vecs[i].emp);
      check($sformatf("v%0d_full", i), full, vecs[i].ful);
      check($sformatf("v%0d_transmit", i), transmit, vecs[i].tx);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
      check($sformatf("v%0d_txdata", i), tx_data, vecs[i].txd);
    end

    // Reset while in WAIT_DONE with five bytes queued.
    wr_en = 1'b1; wr_data = 8'h55; step();
    wr_data = 8'h66; step();
    check("midreset_queued", count, 5);
    reset = 1'b1; wr_data = 8'h77; step();
    check("midreset_count", count, 0);
    check("midreset_txdata", tx_data, 8'h00);
    reset = 1'b0; wr_en = 1'b0; xmode = XM_LOW;
    tx_cycles.delete();
    for (int i = 0; i < 20; i++) step();
    check("midreset_no_launch", tx_cycles.size(), 0);

    // Burst 0x01..0x10 with a 10-cycle busy per frame.
    xmode = XM_AUTO; xm_random = 1'b0; xm_len_fixed = 10;
    launched.delete();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i); step();
    end
    wr_en = 1'b0;
    check("burst_count_after_16", count, 14);
    check("burst_full_after_16", full, 0);
    drain(1000, "burst");
    check("burst_launch_count", launched.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < launched.size()) check($sformatf("burst_order_%0d", i), launched[i], i + 1);

    // Fill to full with busy held high, then one rejected write.
    xmode = XM_HIGH; tx_busy = 1'b1; step();
    launched.delete();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + DW'(i); step();
    end
    check("ovf_count_full", count, 16);
    check("ovf_full", full, 1);
    wr_data = 8'hFF; step();
    check("ovf_pulse", overflow, 1);
    check("ovf_count_held", count, 16);
    wr_en = 1'b0; step();
    check("ovf_pulse_end", overflow, 0);
    xmode = XM_AUTO; xm_len_fixed = 3;
    drain(1000, "ovf");
    check("ovf_launch_count", launched.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < launched.size()) check($sformatf("ovf_order_%0d", i), launched[i], 8'h80 + i);

    // Twenty more bytes to wrap the pointers.
    launched.delete();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + DW'(i); step();
    end
    drain(1000, "wrap");
    check("wrap_launch_count", launched.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < launched.size()) check($sformatf("wrap_order_%0d", i), launched[i], 8'hC0 + i);

    // Busy never rises: error after BT cycles, next byte one cycle later.
    xmode = XM_LOW;
    launched.delete(); tx_cycles.delete(); err_cycles.delete();
    wr_en = 1'b1; wr_data = 8'h77; step();
    wr_data = 8'h78; step();
    wr_en = 1'b0;
    n = 0;
    while (tx_cycles.size() < 2 && n < 100) begin step(); n++; end
    check("timeout_two_launches", tx_cycles.size(), 2);
    check("timeout_one_error", err_cycles.size(), 1);
    if (tx_cycles.size() >= 2 && err_cycles.size() >= 1) begin
      check("timeout_error_delay", err_cycles[0] - tx_cycles[0], BT);
      check("timeout_relaunch_delay", tx_cycles[1] - err_cycles[0], 1);
      check("timeout_second_byte", launched[1], 8'h78);
    end
    drain(200, "timeout");

    // Randomized traffic against the model.
    xmode = XM_AUTO; xm_random = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(99) < 35);
      wr_data = DW'($urandom);
      step();
    end
    drain(3000, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
